mat_softmax_stream: RTL and testbench

- Row-wise fixed-point softmax over a ROWS x COLS score matrix, streamed element by element in row-major order.
- Next generation of the matrix softmax in the attention path: rectangular shape, valid/ready streaming, max-subtraction for stability, iterative divider, per-row output framing.
- Sits between the QK^T score matmul and the attention-weight x V matmul.

---
 rtl/mat_softmax_stream_if.sv | 24 ++
 rtl/mat_softmax_stream.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mat_softmax_stream.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mat_softmax_stream_if.sv
// Streaming bus for mat_softmax_stream: score input channel and probability
// output channel, each a valid/ready handshake. The softmax block takes the
// slave modport; the producer/consumer side takes the master modport.
interface mat_softmax_stream_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic        [WIDTH-1:0] out_data;
  logic                    out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mat_softmax_stream.sv
// Row-wise fixed-point softmax over a ROWS x COLS score matrix streamed in
// row-major order. Each row is loaded, max-subtracted, turned into base-2
// exponentials (2^(d*log2e)), summed, and each element is divided by the sum
// with a restoring divider, then streamed out with per-row out_last framing.
// Optional feature macro: SOFTMAX_CAUSAL_MASK_EN adds a 'causal' input,
// sampled at start, that masks elements above the diagonal to 0.
module mat_softmax_stream #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef SOFTMAX_CAUSAL_MASK_EN
  input  logic causal,
`endif
  output logic busy,
  output logic done,
  mat_softmax_stream_if.slave stream_if
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = WIDTH + $clog2(COLS + 1);
  localparam int KW = $clog2(FBITS + 1);
  localparam int PW = WIDTH + FBITS + 3;

  // round(log2(e) * 2^FBITS), e.g. 369 for FBITS=8
  localparam longint LOG2E_L = (64'sd14426950 * (64'sd1 <<< FBITS) + 64'sd5000000) / 64'sd10000000;
  localparam logic signed [PW-1:0] LOG2E_S = PW'(LOG2E_L);
  localparam logic signed [PW-1:0] WIDTH_S = PW'(WIDTH);
  localparam logic [CW-1:0]        COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(ROWS - 1);
  localparam logic [KW-1:0]        CNT_LAST = KW'(FBITS);
  localparam logic [FBITS:0]       ONE_Q    = {1'b1, {FBITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXP  = 3'd2,
    S_DIV  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic [KW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] max_q;
  logic [SW-1:0]           sum_q;
  logic [WIDTH-1:0]        buf_q [COLS];
  logic [SW-1:0]           div_r_q;
  logic [FBITS-1:0]        div_q_q;
  logic                    causal_q;

  logic                    busy_q, busy_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;

  logic beat_s, accept_s, col_last_s, row_last_s, cnt_last_s, masked_s, causal_in_s;

`ifdef SOFTMAX_CAUSAL_MASK_EN
  assign causal_in_s = causal;
`else
  assign causal_in_s = 1'b0;
`endif

  assign beat_s     = stream_if.in_valid & in_ready_q;
  assign accept_s   = out_valid_q & stream_if.out_ready;
  assign col_last_s = (col_q == COL_LAST);
  assign row_last_s = (row_q == ROW_LAST);
  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign masked_s   = causal_q & (int'(col_q) > int'(row_q));

  // Exponential of the current column: e = (1.f) >> -ip with t = d*log2e
  logic signed [WIDTH-1:0] x_s;
  logic signed [WIDTH:0]   d_s;
  logic signed [PW-1:0]    prod_s, t_s, ip_s, negip_s;
  logic [FBITS-1:0]        f_s;
  logic [WIDTH-1:0]        base_s, exp_e_s;

  assign x_s     = buf_q[col_q];
  assign d_s     = {x_s[WIDTH-1], x_s} - {max_q[WIDTH-1], max_q};
  assign prod_s  = d_s * LOG2E_S;
  assign t_s     = prod_s >>> FBITS;
  assign ip_s    = t_s >>> FBITS;
  assign negip_s = -ip_s;
  assign f_s     = t_s[FBITS-1:0];
  assign base_s  = {{(WIDTH-FBITS-1){1'b0}}, 1'b1, f_s};

  // Select the exponential, flushing masked and fully-underflowed terms to 0
  always_comb begin
    exp_e_s = '0;
    if (masked_s) begin
      exp_e_s = '0;
    end else if (negip_s >= WIDTH_S) begin
      exp_e_s = '0;
    end else begin
      exp_e_s = base_s >> negip_s;
    end
  end

  // Restoring divider step: first step compares e itself, later steps shift
  logic [SW:0]     trial_s;
  logic            ge_s;
  logic [SW-1:0]   div_r_d;
  logic [FBITS:0]  quo_s, sat_s;

  // One quotient bit per cycle, integer bit first then FBITS fraction bits
  always_comb begin
    trial_s = '0;
    if (cnt_q == '0) begin
      trial_s = {1'b0, SW'(buf_q[col_q])};
    end else begin
      trial_s = {div_r_q, 1'b0};
    end
    ge_s = (trial_s >= {1'b0, sum_q});
    if (ge_s) begin
      div_r_d = SW'(trial_s - {1'b0, sum_q});
    end else begin
      div_r_d = trial_s[SW-1:0];
    end
    quo_s = {div_q_q, ge_s};
    if (quo_s > ONE_Q) begin
      sat_s = ONE_Q;
    end else begin
      sat_s = quo_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: load a row, exponentiate, then divide/emit per column
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        if (beat_s && col_last_s) state_d = S_EXP;
        else                      state_d = S_LOAD;
      end
      S_EXP: begin
        if (col_last_s) state_d = S_DIV;
        else            state_d = S_EXP;
      end
      S_DIV: begin
        if (cnt_last_s) state_d = S_OUT;
        else            state_d = S_DIV;
      end
      S_OUT: begin
        if (!accept_s)       state_d = S_OUT;
        else if (!col_last_s) state_d = S_DIV;
        else if (!row_last_s) state_d = S_LOAD;
        else                  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the upcoming state so they can be registered
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT);
    out_last_d  = (state_d == S_OUT) && col_last_s;
    done_d      = (state_d == S_DONE);
    if ((state_q == S_DIV) && cnt_last_s) begin
      out_data_d = {{(WIDTH-FBITS-1){1'b0}}, sat_s};
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
    end
  end

  // Row buffer, running max and sum, column/row/bit counters, divider state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      max_q    <= '0;
      sum_q    <= '0;
      div_r_q  <= '0;
      div_q_q  <= '0;
      causal_q <= 1'b0;
      for (int i = 0; i < COLS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          col_q <= '0;
          row_q <= '0;
          cnt_q <= '0;
          if (start) causal_q <= causal_in_s;
        end
        S_LOAD: begin
          if (beat_s) begin
            buf_q[col_q] <= stream_if.in_data;
            if (col_q == '0) begin
              max_q <= stream_if.in_data;
              sum_q <= '0;
            end else if (!masked_s && (stream_if.in_data > max_q)) begin
              max_q <= stream_if.in_data;
            end
            col_q <= col_last_s ? '0 : col_q + CW'(1);
          end
        end
        S_EXP: begin
          buf_q[col_q] <= exp_e_s;
          sum_q        <= sum_q + SW'(exp_e_s);
          col_q        <= col_last_s ? '0 : col_q + CW'(1);
          cnt_q        <= '0;
        end
        S_DIV: begin
          div_r_q <= div_r_d;
          div_q_q <= quo_s[FBITS-1:0];
          cnt_q   <= cnt_last_s ? '0 : cnt_q + KW'(1);
        end
        S_OUT: begin
          if (accept_s) begin
            if (col_last_s) begin
              col_q <= '0;
              row_q <= row_last_s ? '0 : row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        S_DONE: begin
          col_q <= '0;
          row_q <= '0;
        end
        default: begin
          col_q <= '0;
          row_q <= '0;
        end
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign stream_if.in_ready  = in_ready_q;
  assign stream_if.out_valid = out_valid_q;
  assign stream_if.out_data  = out_data_q;
  assign stream_if.out_last  = out_last_q;

endmodule

// File: tb/tb_mat_softmax_stream.sv
// Self-checking bench for mat_softmax_stream: directed rows with hand-derived
// probabilities, random matrices against a plain-arithmetic softmax model,
// input gaps, output backpressure, mid-matrix reset and start-while-busy.
module tb_mat_softmax_stream;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int WIDTH = 32;
  localparam int FBITS = 8;
  localparam int N     = ROWS * COLS;
  localparam longint LOG2E_Q = 369;
  localparam longint ONE     = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
`ifdef SOFTMAX_CAUSAL_MASK_EN
  logic causal = 1'b0;
`endif

  mat_softmax_stream_if #(.WIDTH(WIDTH)) bus ();

  mat_softmax_stream #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef SOFTMAX_CAUSAL_MASK_EN
    .causal   (causal),
`endif
    .busy     (busy),
    .done     (done),
    .stream_if(bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint mat   [N];
  longint exp_q [N];

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference softmax: max-subtract, base-2 exponential, floor division
  function automatic void build_expected();
    for (int r = 0; r < ROWS; r++) begin
      longint mx, sum, d, t, ip, f, sh, q;
      longint e_v [COLS];
      mx = mat[r*COLS];
      for (int c = 1; c < COLS; c++) if (mat[r*COLS+c] > mx) mx = mat[r*COLS+c];
      sum = 0;
      for (int c = 0; c < COLS; c++) begin
        d  = mat[r*COLS+c] - mx;
        t  = (d * LOG2E_Q) >>> FBITS;
        ip = t >>> FBITS;
        f  = t - (ip <<< FBITS);
        sh = -ip;
        e_v[c] = (sh >= WIDTH) ? 0 : ((ONE + f) >> sh);
        sum += e_v[c];
      end
      for (int c = 0; c < COLS; c++) begin
        q = (e_v[c] * ONE) / sum;
        if (q > ONE) q = ONE;
        exp_q[r*COLS+c] = q;
      end
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_in_ready"}, bus.in_ready, 0);
    check_val({tag, "_out_valid"}, bus.out_valid, 0);
    check_val({tag, "_out_last"}, bus.out_last, 0);
    check_val({tag, "_out_data"}, bus.out_data, 0);
  endtask

  // Stream one matrix in and out; optional input gaps, a 20-cycle stall at
  // output index stall_at, a start pulse while busy, or a reset during row 1
  task automatic run_matrix(input bit gap, input int stall_at, input bit abort, input bit poke_start);
    int in_idx = 0, out_idx = 0, cyc = 0, stall = 0, abort_cnt = 0, early_done = 0;
    bit fin = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("in_ready_after_start", bus.in_ready, 1);
    while (!fin && cyc < 3000) begin
      if (out_idx == N) begin
        bus.out_ready = 1'b0;
        check_val("done_pulse", done, 1);
        @(negedge clk);
        check_val("done_single", done, 0);
        check_val("busy_after_done", busy, 0);
        check_val("done_early", early_done, 0);
        fin = 1'b1;
        break;
      end
      if (done) early_done++;
      if (abort && in_idx >= 2*COLS) begin
        abort_cnt++;
        if (abort_cnt == 8) begin
          rst_n = 1'b0;
          #1;
          check_idle_outputs("abort_reset");
          fin = 1'b1;
          break;
        end
      end
      bus.out_ready = 1'b0;
      if (bus.out_valid) begin
        if (out_idx == stall_at && stall < 20) begin
          stall++;
          check_val("stall_data", bus.out_data, exp_q[out_idx]);
          check_val("stall_last", bus.out_last, (out_idx % COLS) == COLS-1);
        end else begin
          check_val("out_data", bus.out_data, exp_q[out_idx]);
          check_val("out_last", bus.out_last, (out_idx % COLS) == COLS-1);
          bus.out_ready = 1'b1;
          out_idx++;
        end
      end
      if (in_idx < N) begin
        bus.in_valid = gap ? (cyc % 2 == 0) : 1'b1;
        bus.in_data  = mat[in_idx][WIDTH-1:0];
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      start = (poke_start && cyc == 25);
      @(negedge clk);
      cyc++;
    end
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (!fin) check_val("timeout", cyc, -1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform rows of 0x40 -> 64 everywhere
    for (int i = 0; i < N; i++) begin mat[i] = 64; exp_q[i] = 64; end
    run_matrix(1'b0, -1, 1'b0, 1'b0);

    // Hand-derived rows, gapped input, output stall, start while busy
    begin
      longint rows_in  [N] = '{256, 0, 0, 0,  4096, 0, 0, 0,  -64, -64, -64, -64,  64, 64, 64, 64};
      longint rows_exp [N] = '{118, 45, 45, 45,  256, 0, 0, 0,  64, 64, 64, 64,  64, 64, 64, 64};
      for (int i = 0; i < N; i++) begin mat[i] = rows_in[i]; exp_q[i] = rows_exp[i]; end
    end
    run_matrix(1'b1, 6, 1'b0, 1'b1);

    // Random matrices in a range where several elements survive
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) mat[i] = longint'($urandom_range(0, 4095)) - 2048;
      build_expected();
      run_matrix(k[0], (k == 2) ? 9 : -1, 1'b0, 1'b0);
    end

    // Full-range random scores
    for (int i = 0; i < N; i++) mat[i] = longint'(int'($urandom));
    build_expected();
    run_matrix(1'b0, -1, 1'b0, 1'b0);

    // Reset during row 1, then a clean matrix with no leftovers
    for (int i = 0; i < N; i++) mat[i] = longint'($urandom_range(0, 1023)) - 512;
    build_expected();
    run_matrix(1'b0, -1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("after_abort");
    for (int i = 0; i < N; i++) mat[i] = longint'($urandom_range(0, 511)) - 256;
    build_expected();
    run_matrix(1'b1, 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
